axi4_mgr_sched: RTL
===================

// Module: axi4_mgr_sched
// PURPOSE
//  Round-robin scheduler sharing one non-pipelined AXI4 manager between NUM_REQ requesters.
//  Each requester posts a read or write job (address, beat count); one job is outstanding at a time.
//  Forwards the granted job on the manager's req/addr/count interface, waits for completion,
//  returns done/error/timeout status to the owner. Sits between DMA-style clients and the manager.
// PARAMETERS
//  NUM_REQ           4     number of requesters (2..8)
//  AXI_ADDR_WIDTH    32    address width
//  DATA_COUNT_WIDTH  8     beat-count width
//  TIMEOUT_CYCLES    1024  WAIT cycles before a job is aborted with timeout (>=2)
// PORTS
//  clk_i           in   1                     clock
//  rstn_i          in   1                     async active-low reset
//  req_valid_i     in   NUM_REQ               job request, held until req_ready_o
//  req_rd_i        in   NUM_REQ               1=read job, 0=write job
//  req_addr_i      in   NUM_REQ*ADDR_W        per-requester start address (slice i)
//  req_count_i     in   NUM_REQ*DCW           per-requester beat count (slice i)
//  req_ready_o     out  NUM_REQ               one-cycle accept pulse (onehot)
//  done_o          out  NUM_REQ               one-cycle completion pulse (onehot)
//  err_o           out  2                     resp of last job, valid with done_o
//  timeout_o       out  1                     high with done_o if job timed out
//  busy_o          out  1                     high in any state except IDLE
//  mgr_req_o       out  2                     to manager req_i: bit1 rd, bit0 wr
//  mgr_wr_addr_o   out  ADDR_W                to manager write address
//  mgr_rd_addr_o   out  ADDR_W                to manager read address
//  mgr_wr_count_o  out  DCW                   to manager write data count
//  mgr_rd_count_o  out  DCW                   to manager read data count
//  mgr_done_i      in   2                     completion pulse: bit1 rd, bit0 wr
//  mgr_err_i       in   2                     resp code, sampled with mgr_done_i
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last-grant pointer = NUM_REQ-1, timeout counter 0.
//  FSM IDLE->ISSUE->WAIT->DONE->IDLE.
//   IDLE:  scan from (last_grant+1) mod NUM_REQ upward; first requester with req_valid_i=1 wins.
//          Register grant index, rd flag, addr, count; go ISSUE. No valid requester: stay.
//   ISSUE: req_ready_o[grant]=1 for exactly this cycle.
//          count!=0: mgr_req_o bit (rd?1:0)=1 for this cycle only, then WAIT.
//          count==0: no manager request, go DONE with err 0.
//   WAIT:  mgr addr/count outputs held stable (unused direction = 0). Counter increments per cycle.
//          mgr_done_i on the matching bit -> capture mgr_err_i, go DONE.
//          Counter reaches TIMEOUT_CYCLES-1 without done -> go DONE, timeout_o=1, err_o=2'b10.
//   DONE:  done_o[grant]=1, err_o/timeout_o valid this cycle only; last_grant<=grant; clear
//          counter and mgr outputs; go IDLE.
//  Latency: valid seen in IDLE cycle 0 -> ready/mgr_req cycle 1 -> mgr done cycle k -> done_o k+1.
//   Back-to-back: next grant decided in IDLE cycle k+2.
//  mgr_done_i outside WAIT, or on the non-matching bit, is ignored (no state change).
//  Both mgr_done_i bits set in WAIT: matching bit completes the job, other bit ignored.
//  req_valid_i deasserted after grant: job still completes; fields already registered.
//  Requester-side inputs changing during ISSUE/WAIT/DONE have no effect.
//  Reset mid-job: all state cleared asynchronously; no done_o is generated for the aborted job.
//  Pointer wrap: index arithmetic modulo NUM_REQ; a grant never repeats while others wait.
// TESTING
//  1 Single write, req0 addr 0x1000 count 4; mgr_done_i=01 after 10 cyc -> mgr_req_o=01 once,
//    mgr_wr_addr_o=0x1000, mgr_wr_count_o=4, done_o=0001, err_o=00.
//  2 req0..3 all valid, held continuously -> grant order 0,1,2,3,0; each ready_o one cycle.
//  3 Read req2 count 8; mgr_done_i=10 with mgr_err_i=10 -> done_o=0100, err_o=10, timeout_o=0.
//  4 Write job, mgr_done_i never asserted -> done_o after TIMEOUT_CYCLES in WAIT,
//    timeout_o=1, err_o=10; next job issues normally.
//  5 count 0 on req1 -> ready_o and done_o pulses, mgr_req_o stays 00; stray mgr_done_i in IDLE
//    ignored.
//  6 rstn_i low during WAIT -> all outputs 0 asynchronously; after release, pointer=NUM_REQ-1,
//    req0 wins first.

Source files
------------

// File: rtl/axi4_mgr_sched.sv
// ---------------------------------------------------------------------------
// axi4_mgr_sched
//
// Round-robin scheduler that shares one non-pipelined AXI4 manager between
// NUM_REQ requesters. One job is outstanding at a time: the granted job is
// forwarded on the manager's req/addr/count interface, the scheduler waits
// for the manager's completion pulse (or a timeout), then returns a one-cycle
// done pulse plus status to the owner.
//
// Ports
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   req_valid_i      per-requester job request, held until req_ready_o
//   req_rd_i         per-requester direction: 1 = read, 0 = write
//   req_addr_i       per-requester start address, slice i
//   req_count_i      per-requester beat count, slice i
//   req_ready_o      one-cycle onehot accept pulse
//   done_o           one-cycle onehot completion pulse
//   err_o            response code of the finished job, valid with done_o
//   timeout_o        high with done_o when the job was aborted by timeout
//   busy_o           high whenever the FSM is not IDLE
//   mgr_req_o        manager request pulse: bit1 read, bit0 write
//   mgr_wr_addr_o    manager write address (0 while a read is in flight)
//   mgr_rd_addr_o    manager read address (0 while a write is in flight)
//   mgr_wr_count_o   manager write beat count
//   mgr_rd_count_o   manager read beat count
//   mgr_done_i       manager completion pulse: bit1 read, bit0 write
//   mgr_err_i        manager response code, sampled with mgr_done_i
//   dbg_state_o      current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
//
// Handshake: a requester raises req_valid_i with its rd/addr/count fields and
// keeps them stable until it sees its req_ready_o bit. The fields are captured
// when the grant is decided, so after req_ready_o the requester may drop or
// change anything; it then waits for its done_o bit.
// ---------------------------------------------------------------------------
module axi4_mgr_sched #(
  parameter int NUM_REQ          = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int DATA_COUNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  input  logic [NUM_REQ-1:0]                     req_rd_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]    req_count_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  output logic [NUM_REQ-1:0]                     done_o,
  output logic [1:0]                             err_o,
  output logic                                   timeout_o,
  output logic                                   busy_o,
  output logic [1:0]                             mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]              mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]              mgr_rd_addr_o,
  output logic [DATA_COUNT_WIDTH-1:0]            mgr_wr_count_o,
  output logic [DATA_COUNT_WIDTH-1:0]            mgr_rd_count_o,
  input  logic [1:0]                             mgr_done_i,
  input  logic [1:0]                             mgr_err_i,
  output logic [1:0]                             dbg_state_o
);

  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DCW = DATA_COUNT_WIDTH;
  localparam int IW  = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant;
  logic          rd_q;
  logic          count_zero;
  logic [CW-1:0] tmo_cnt;

  // Round-robin pick: scan upward starting one past the last grant so the
  // most recently served requester is considered last.
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((int'(last_grant) + off) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic           pick_rd;
  logic [AW-1:0]  pick_addr;
  logic [DCW-1:0] pick_count;

  assign pick_rd    = req_rd_i[pick_idx];
  assign pick_addr  = req_addr_i[int'(pick_idx)*AW +: AW];
  assign pick_count = req_count_i[int'(pick_idx)*DCW +: DCW];

  // Only the completion bit matching the job's direction counts.
  logic mgr_match;
  assign mgr_match = rd_q ? mgr_done_i[1] : mgr_done_i[0];

  assign busy_o      = (state != ST_IDLE);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= ST_IDLE;
      last_grant     <= IW'(NUM_REQ - 1);
      grant          <= '0;
      rd_q           <= 1'b0;
      count_zero     <= 1'b0;
      tmo_cnt        <= '0;
      req_ready_o    <= '0;
      done_o         <= '0;
      err_o          <= 2'b00;
      timeout_o      <= 1'b0;
      mgr_req_o      <= 2'b00;
      mgr_wr_addr_o  <= '0;
      mgr_rd_addr_o  <= '0;
      mgr_wr_count_o <= '0;
      mgr_rd_count_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant       <= pick_idx;
            rd_q        <= pick_rd;
            count_zero  <= (pick_count == '0);
            req_ready_o <= ONE << pick_idx;
            // A zero-beat job never reaches the manager.
            if (pick_count != '0) begin
              if (pick_rd) begin
                mgr_req_o      <= 2'b10;
                mgr_rd_addr_o  <= pick_addr;
                mgr_rd_count_o <= pick_count;
              end else begin
                mgr_req_o      <= 2'b01;
                mgr_wr_addr_o  <= pick_addr;
                mgr_wr_count_o <= pick_count;
              end
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          req_ready_o <= '0;
          mgr_req_o   <= 2'b00;
          tmo_cnt     <= '0;
          if (count_zero) begin
            done_o    <= ONE << grant;
            err_o     <= 2'b00;
            timeout_o <= 1'b0;
            state     <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // A real completion wins over a timeout in the same cycle.
          if (mgr_match) begin
            done_o    <= ONE << grant;
            err_o     <= mgr_err_i;
            timeout_o <= 1'b0;
            state     <= ST_DONE;
          end else if (tmo_cnt == CNT_LAST) begin
            done_o    <= ONE << grant;
            err_o     <= 2'b10;
            timeout_o <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          done_o         <= '0;
          err_o          <= 2'b00;
          timeout_o      <= 1'b0;
          last_grant     <= grant;
          tmo_cnt        <= '0;
          mgr_wr_addr_o  <= '0;
          mgr_rd_addr_o  <= '0;
          mgr_wr_count_o <= '0;
          mgr_rd_count_o <= '0;
          state          <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
